// File: rtl/nand_uart_sequencer.sv
// Byte-stream command sequencer: decodes framed UART host commands, drives nand_master
// activate/cmd_in/data_in, and returns data_out bytes followed by a status byte.
module nand_uart_sequencer #(
  parameter int unsigned CMD_W       = 6,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned RX_GAP_CYC  = 65535,
  parameter logic [7:0]  ST_OK       = 8'h00,
  parameter logic [7:0]  ST_TIMEOUT  = 8'hE1,
  parameter logic [7:0]  ST_GAP      = 8'hE2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CMD_W-1:0] cmd_in,
  output logic [7:0]       data_in,
  output logic             activate,
  input  logic             busy,
  input  logic [7:0]       data_out,
  output logic             frame_active,
  output logic [7:0]       last_status
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = $clog2(RX_GAP_CYC + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(RX_GAP_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ARG, GET_CNT, ISSUE, SETTLE, WAIT, SEND_DATA, SEND_STAT
  } state_t;

  state_t        state, next;
  logic          rpt_f;
  logic [8:0]    rem;
  logic [TW-1:0] tmo;
  logic [GW-1:0] gap;
  logic [SW-1:0] settle;
  logic          rx_fire, tx_fire, gap_last, tmo_last, settle_last;

  assign rx_ready     = nreset && (state == IDLE || state == GET_ARG || state == GET_CNT);
  assign rx_fire      = rx_valid && rx_ready;
  assign tx_valid     = (state == SEND_DATA) || (state == SEND_STAT);
  assign tx_fire      = tx_valid && tx_ready;
  assign activate     = (state == ISSUE);
  // Header accept leaves IDLE and status accept is the only way back, so this tracks the frame exactly.
  assign frame_active = (state != IDLE);
  assign gap_last     = (gap == GAP_LAST);
  assign tmo_last     = (tmo == TMO_LAST);
  assign settle_last  = (settle == SETTLE_LAST);

  always_comb begin
    next = state;
    case (state)
      IDLE:      if (rx_fire) next = rx_data[7] ? GET_ARG : (rx_data[6] ? GET_CNT : ISSUE);
      GET_ARG:   if (rx_fire) next = rpt_f ? GET_CNT : ISSUE;
                 else if (gap_last) next = SEND_STAT;
      GET_CNT:   if (rx_fire) next = ISSUE;
                 else if (gap_last) next = SEND_STAT;
      ISSUE:     next = SETTLE;
      SETTLE:    if (settle_last) next = WAIT;
      WAIT:      if (!busy) next = rpt_f ? SEND_DATA : SEND_STAT;
                 else if (tmo_last) next = SEND_STAT;
      SEND_DATA: if (tx_fire) next = (rem == 9'd1) ? SEND_STAT : ISSUE;
      SEND_STAT: if (tx_fire) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      rpt_f       <= 1'b0;
      rem         <= '0;
      tmo         <= '0;
      gap         <= '0;
      settle      <= '0;
      cmd_in      <= '0;
      data_in     <= '0;
      tx_data     <= '0;
      last_status <= ST_OK;
    end else begin
      state <= next;
      case (state)
        IDLE: if (rx_fire) begin
          cmd_in <= rx_data[CMD_W-1:0];
          rpt_f  <= rx_data[6];
          rem    <= 9'd1;
          gap    <= '0;
        end
        GET_ARG, GET_CNT: begin
          if (rx_fire) begin
            gap <= '0;
            if (state == GET_ARG) data_in <= rx_data;
            else                  rem     <= {1'b0, rx_data} + 9'd1;
          end else if (gap_last) begin
            tx_data <= ST_GAP;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        ISSUE: begin
          settle <= '0;
          tmo    <= '0;
        end
        SETTLE: settle <= settle + 1'b1;
        WAIT: begin
          if (!busy)         tx_data <= rpt_f ? data_out : ST_OK;
          else if (tmo_last) tx_data <= ST_TIMEOUT;
          else               tmo     <= tmo + 1'b1;
        end
        SEND_DATA: if (tx_fire) begin
          rem <= rem - 9'd1;
          if (rem == 9'd1) tx_data <= ST_OK;
        end
        SEND_STAT: if (tx_fire) last_status <= tx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_uart_sequencer.sv
// Scoreboard bench for nand_uart_sequencer with a behavioural nand_master busy/data model.
module tb_nand_uart_sequencer;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [5:0] cmd_in;
  logic [7:0] data_in;
  logic       activate;
  logic       busy = 1'b0;
  logic [7:0] data_out = '0;
  logic       frame_active;
  logic [7:0] last_status;

  always #5 clk = ~clk;

  nand_uart_sequencer #(
    .CMD_W(6), .SETTLE_CYC(2), .TIMEOUT_CYC(100), .RX_GAP_CYC(20),
    .ST_OK(8'h00), .ST_TIMEOUT(8'hE1), .ST_GAP(8'hE2)
  ) dut (
    .clk(clk), .nreset(nreset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_in(cmd_in), .data_in(data_in), .activate(activate),
    .busy(busy), .data_out(data_out),
    .frame_active(frame_active), .last_status(last_status)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [7:0]  sb[$];
  logic [5:0]  exp_cmd = '0;
  logic [7:0]  exp_din = '0;
  int unsigned act_cnt = 0;
  int unsigned iter = 0;
  int unsigned busy_len = 0;
  int unsigned bcnt = 0;
  logic        stuck = 1'b0;
  logic        tx_rand = 1'b0;
  logic        hold_pending = 1'b0;
  logic [7:0]  held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor, tx scoreboard and nand_master model; everything here acts at the falling edge.
  always @(negedge clk) begin
    tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!nreset) begin
      busy = 1'b0;
      bcnt = 0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && tx_valid) check("tx_hold", tx_data, held);
      hold_pending = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else                check("tx_data", tx_data, sb.pop_front());
      end
      if (activate) begin
        check("cmd_in", cmd_in, exp_cmd);
        check("data_in", data_in, exp_din);
        check("act_vs_tx", tx_valid, 0);
        act_cnt++;
        data_out = iter[7:0];
        iter++;
        busy = stuck || (busy_len != 0);
        bcnt = busy_len;
      end else if (busy && !stuck) begin
        if (bcnt > 1) bcnt--;
        else busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_wait", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [5:0] c, input logic [7:0] d, input int unsigned bl);
    exp_cmd = c;
    exp_din = d;
    busy_len = bl;
    act_cnt = 0;
    iter = 0;
  endtask

  task automatic wait_done(input int unsigned acts, input logic [7:0] st);
    int unsigned n = 0;
    while (frame_active && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("frame_end", frame_active, 0);
    check("sb_drained", sb.size(), 0);
    check("act_count", act_cnt, acts);
    check("last_status", last_status, st);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_activate", activate, 0);
    check("rst_cmd_in", cmd_in, 0);
    check("rst_data_in", data_in, 0);
    check("rst_frame", frame_active, 0);
    check("rst_last_st", last_status, 8'h00);
  endtask

  initial begin
    int unsigned n;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    nreset = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", rx_ready, 1);

    // Simple command, long busy
    start_frame(6'h01, 8'h00, 50);
    sb.push_back(8'h00);
    send_byte(8'h01);
    check("act_next_cycle", activate, 1);
    wait_done(1, 8'h00);

    // Argument, busy never high
    start_frame(6'h0E, 8'h00, 0);
    sb.push_back(8'h00);
    send_byte(8'h8E);
    send_byte(8'h00);
    wait_done(1, 8'h00);

    // Repeat count 7 with random tx backpressure; data_in retained from previous frame
    start_frame(6'h13, 8'h00, 3);
    tx_rand = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(8'(i));
    sb.push_back(8'h00);
    send_byte(8'h53);
    send_byte(8'h07);
    wait_done(8, 8'h00);
    tx_rand = 1'b0;

    // Busy stuck high: timeout after SETTLE (2) + 100 WAIT cycles
    start_frame(6'h09, 8'h00, 0);
    stuck = 1'b1;
    sb.push_back(8'hE1);
    send_byte(8'h09);
    n = 0;
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, 103);
    wait_done(1, 8'hE1);
    stuck = 1'b0;
    repeat (2) @(negedge clk);

    // RX gap after ARG header, then a normal frame
    start_frame(6'h0E, 8'h00, 0);
    sb.push_back(8'hE2);
    send_byte(8'h8E);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gap_latency", n, 20);
    wait_done(0, 8'hE2);
    start_frame(6'h01, 8'h00, 5);
    sb.push_back(8'h00);
    send_byte(8'h01);
    wait_done(1, 8'h00);

    // Count 0xFF: 256 iterations
    start_frame(6'h02, 8'h00, 0);
    for (int i = 0; i < 256; i++) sb.push_back(8'(i));
    sb.push_back(8'h00);
    send_byte(8'h42);
    send_byte(8'hFF);
    wait_done(256, 8'h00);

    // Argument captured, then retained by a header-only frame
    start_frame(6'h01, 8'h3C, 1);
    sb.push_back(8'h00);
    send_byte(8'h81);
    send_byte(8'h3C);
    wait_done(1, 8'h00);
    start_frame(6'h07, 8'h3C, 1);
    sb.push_back(8'h00);
    send_byte(8'h07);
    wait_done(1, 8'h00);

    // Reset in WAIT of a repeat frame
    start_frame(6'h05, 8'h5A, 30);
    send_byte(8'hC5);
    send_byte(8'h5A);
    send_byte(8'h03);
    repeat (10) @(negedge clk);
    check("pre_rst_frame", frame_active, 1);
    #2 nreset = 1'b0;
    #1 check_reset_outputs();
    sb.delete();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    start_frame(6'h01, 8'h00, 2);
    sb.push_back(8'h00);
    send_byte(8'h01);
    wait_done(1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
